// File: rtl/rice_core_bus_arbiter.sv
// rice_core_bus_arbiter
//   Shares one memory bus between the core's instruction-fetch port and its
//   data (load/store) port. The grant is chosen combinationally and held in a
//   lock register while the memory stalls. Each accepted request pushes the
//   grantee ID into an ID FIFO. In-order memory responses pop the FIFO head
//   and are routed back to the requester that issued them.
//
// Configuration macro
//   RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
//     defined   : round robin; priority flips to the other port after each handshake
//     undefined : fixed priority, data port over instruction port
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_inst_request_*/o_inst_*    fetch port (read only), response has no backpressure
//   i_data_request_*/o_data_*    load/store port, response has no backpressure
//   o_mem_request_*/i_mem_*      shared memory bus, responses strictly in request order
//
// State | meaning
//   ST_IDLE      | no grant held; pick a requester each cycle
//   ST_LOCK_INST | fetch request presented but stalled; hold grant until handshake
//   ST_LOCK_DATA | data request presented but stalled; hold grant until handshake

module rice_core_bus_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_inst_request_valid,
    output logic                      o_inst_request_ready,
    input  logic [ADDRESS_WIDTH-1:0]  i_inst_address,
    output logic                      o_inst_response_valid,
    output logic [DATA_WIDTH-1:0]     o_inst_response_data,
    output logic                      o_inst_response_error,
    input  logic                      i_data_request_valid,
    output logic                      o_data_request_ready,
    input  logic [ADDRESS_WIDTH-1:0]  i_data_address,
    input  logic                      i_data_write,
    input  logic [DATA_WIDTH-1:0]     i_data_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_data_strobe,
    output logic                      o_data_response_valid,
    output logic [DATA_WIDTH-1:0]     o_data_response_data,
    output logic                      o_data_response_error,
    output logic                      o_mem_request_valid,
    input  logic                      i_mem_request_ready,
    output logic [ADDRESS_WIDTH-1:0]  o_mem_address,
    output logic                      o_mem_write,
    output logic [DATA_WIDTH-1:0]     o_mem_write_data,
    output logic [DATA_WIDTH/8-1:0]   o_mem_strobe,
    input  logic                      i_mem_response_valid,
    input  logic [DATA_WIDTH-1:0]     i_mem_response_data,
    input  logic                      i_mem_response_error
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } state_t;

    state_t                     state;
    logic [CW-1:0]              count;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [MAX_OUTSTANDING-1:0] id_fifo;   // 0 = inst, 1 = data

    logic sel_inst;
    logic sel_data;
    logic fifo_full;
    logic handshake;
    logic pop;
    logic head_id;

`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
    logic rr_data_first;
`endif

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Uses the registered count, so a response arriving this cycle cannot
    // open a slot for an issue in the same cycle.
    assign fifo_full = (count == CW'(MAX_OUTSTANDING));

    always_comb begin
        sel_inst = 1'b0;
        sel_data = 1'b0;
        if (!fifo_full) begin
            case (state)
                ST_LOCK_INST: sel_inst = 1'b1;
                ST_LOCK_DATA: sel_data = 1'b1;
                default: begin
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
                    if (rr_data_first) begin
                        if (i_data_request_valid)      sel_data = 1'b1;
                        else if (i_inst_request_valid) sel_inst = 1'b1;
                    end else begin
                        if (i_inst_request_valid)      sel_inst = 1'b1;
                        else if (i_data_request_valid) sel_data = 1'b1;
                    end
`else
                    if (i_data_request_valid)      sel_data = 1'b1;
                    else if (i_inst_request_valid) sel_inst = 1'b1;
`endif
                end
            endcase
        end
    end

    assign o_mem_request_valid  = (sel_inst & i_inst_request_valid) |
                                  (sel_data & i_data_request_valid);
    assign o_inst_request_ready = sel_inst & i_mem_request_ready;
    assign o_data_request_ready = sel_data & i_mem_request_ready;
    assign handshake            = o_mem_request_valid & i_mem_request_ready;

    // Fetches are reads: write controls stay at zero while the inst port owns the bus.
    assign o_mem_address    = sel_data ? i_data_address :
                              (sel_inst ? i_inst_address : '0);
    assign o_mem_write      = sel_data & i_data_write;
    assign o_mem_write_data = sel_data ? i_data_write_data : '0;
    assign o_mem_strobe     = sel_data ? i_data_strobe : '0;

    // A response with nothing outstanding (e.g. after a reset) is dropped.
    assign pop     = i_mem_response_valid & (count != '0);
    assign head_id = id_fifo[rd_ptr];

    assign o_inst_response_valid = pop & ~head_id;
    assign o_inst_response_data  = (pop & ~head_id) ? i_mem_response_data : '0;
    assign o_inst_response_error = pop & ~head_id & i_mem_response_error;
    assign o_data_response_valid = pop & head_id;
    assign o_data_response_data  = (pop & head_id) ? i_mem_response_data : '0;
    assign o_data_response_error = pop & head_id & i_mem_response_error;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            id_fifo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (o_mem_request_valid && !i_mem_request_ready)
                        state <= sel_data ? ST_LOCK_DATA : ST_LOCK_INST;
                end
                ST_LOCK_INST, ST_LOCK_DATA: begin
                    if (handshake)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (handshake) begin
                id_fifo[wr_ptr] <= sel_data;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);

            case ({handshake, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            rr_data_first <= 1'b0;
        else if (handshake)
            rr_data_first <= sel_inst;
    end
`endif

endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
module tb_rice_core_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inst_valid, inst_ready;
    logic [AW-1:0]     inst_addr;
    logic              inst_rvalid, inst_rerr;
    logic [DW-1:0]     inst_rdata;
    logic              data_valid, data_ready, data_write;
    logic [AW-1:0]     data_addr;
    logic [DW-1:0]     data_wdata;
    logic [DW/8-1:0]   data_strobe;
    logic              data_rvalid, data_rerr;
    logic [DW-1:0]     data_rdata;
    logic              mem_valid, mem_ready, mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_strobe;
    logic              mem_rvalid, mem_rerr;
    logic [DW-1:0]     mem_rdata;

    always #5 clk = ~clk;

    rice_core_bus_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_request_valid(inst_valid), .o_inst_request_ready(inst_ready),
        .i_inst_address(inst_addr),
        .o_inst_response_valid(inst_rvalid), .o_inst_response_data(inst_rdata),
        .o_inst_response_error(inst_rerr),
        .i_data_request_valid(data_valid), .o_data_request_ready(data_ready),
        .i_data_address(data_addr), .i_data_write(data_write),
        .i_data_write_data(data_wdata), .i_data_strobe(data_strobe),
        .o_data_response_valid(data_rvalid), .o_data_response_data(data_rdata),
        .o_data_response_error(data_rerr),
        .o_mem_request_valid(mem_valid), .i_mem_request_ready(mem_ready),
        .o_mem_address(mem_addr), .o_mem_write(mem_write),
        .o_mem_write_data(mem_wdata), .o_mem_strobe(mem_strobe),
        .i_mem_response_valid(mem_rvalid), .i_mem_response_data(mem_rdata),
        .i_mem_response_error(mem_rerr)
    );

    typedef struct {logic write; logic [AW-1:0] addr;} iss_t;
    typedef struct {logic port; logic [DW-1:0] data; logic err;} rsp_t;

    iss_t iss_q[$];
    rsp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   outstanding = 0;
    bit   stray_ok = 1'b0;

    // Scoreboard: issued requests and routed responses are popped and
    // compared as the DUT produces them.
    always @(negedge clk) begin
        iss_t e;
        rsp_t r;
        logic          got_port;
        logic [DW-1:0] got_data;
        logic          got_err;
        if (rst) begin
            outstanding = 0;
        end else begin
            if (mem_rvalid) begin
                if (outstanding == 0) begin
                    if (!stray_ok) begin
                        tests++; fails++;
                        $display("FAIL stray_response: response with nothing outstanding at %0t", $time);
                    end
                end else begin
                    outstanding--;
                end
            end
            if (mem_valid && mem_ready) begin
                outstanding++;
                tests++;
                if (iss_q.size() == 0) begin
                    fails++;
                    $display("FAIL issue_unexpected: addr=%h write=%b, none expected", mem_addr, mem_write);
                end else begin
                    e = iss_q.pop_front();
                    if (mem_addr !== e.addr || mem_write !== e.write) begin
                        fails++;
                        $display("FAIL issue_order: got addr=%h write=%b, expected addr=%h write=%b",
                                 mem_addr, mem_write, e.addr, e.write);
                    end
                end
            end
            if (inst_rvalid || data_rvalid) begin
                tests++;
                got_port = data_rvalid;
                got_data = data_rvalid ? data_rdata : inst_rdata;
                got_err  = data_rvalid ? data_rerr : inst_rerr;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL response_unexpected: port=%0d data=%h", got_port, got_data);
                end else begin
                    r = exp_q.pop_front();
                    if ((inst_rvalid && data_rvalid) || got_port !== r.port ||
                        got_data !== r.data || got_err !== r.err) begin
                        fails++;
                        $display("FAIL response_route: got port=%0d data=%h err=%b both=%b, expected port=%0d data=%h err=%b",
                                 got_port, got_data, got_err, inst_rvalid && data_rvalid, r.port, r.data, r.err);
                    end
                end
            end
            tests++;
            if ((!inst_rvalid && (inst_rdata !== '0 || inst_rerr !== 1'b0)) ||
                (!data_rvalid && (data_rdata !== '0 || data_rerr !== 1'b0))) begin
                fails++;
                $display("FAIL idle_response_zero: inst d=%h e=%b data d=%h e=%b, expected zeros",
                         inst_rdata, inst_rerr, data_rdata, data_rerr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        inst_valid = 0; inst_addr = '0;
        data_valid = 0; data_addr = '0; data_write = 0; data_wdata = '0; data_strobe = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rerr = 0;
        stray_ok = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        iss_q.delete();
        exp_q.delete();
    endtask

    task automatic respond(input logic [DW-1:0] d, input logic err);
        mem_rvalid = 1'b1; mem_rdata = d; mem_rerr = err;
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests++;
        if (mem_valid !== 0 || inst_ready !== 0 || data_ready !== 0 || mem_addr !== '0 ||
            mem_write !== 0 || mem_wdata !== '0 || mem_strobe !== '0 ||
            inst_rvalid !== 0 || data_rvalid !== 0) begin
            fails++;
            $display("FAIL reset_outputs: mem_valid=%b ready=%b/%b addr=%h rvalid=%b/%b, expected all 0",
                     mem_valid, inst_ready, data_ready, mem_addr, inst_rvalid, data_rvalid);
        end
        cyc();
        stray_ok = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        tests++;
        if (inst_rvalid !== 0 || data_rvalid !== 0) begin
            fails++;
            $display("FAIL empty_fifo_drop: rvalid inst=%b data=%b, expected 0/0", inst_rvalid, data_rvalid);
        end
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        stray_ok = 1'b0;
    endtask

    task automatic test_inst_read();
        apply_reset();
        mem_ready = 1; inst_valid = 1; inst_addr = 32'h100; data_wdata = 32'h5555_AAAA;
        iss_q.push_back('{write: 1'b0, addr: 32'h100});
        @(negedge clk);
        tests++;
        if (inst_ready !== 1 || data_ready !== 0 || mem_write !== 0 ||
            mem_wdata !== '0 || mem_strobe !== '0) begin
            fails++;
            $display("FAIL inst_request: ready=%b/%b write=%b wdata=%h strobe=%h, expected 1/0 0 0 0",
                     inst_ready, data_ready, mem_write, mem_wdata, mem_strobe);
        end
        cyc();
        inst_valid = 0;
        cyc();
        cyc();
        exp_q.push_back('{port: 1'b0, data: 32'hDEAD_BEEF, err: 1'b0});
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (inst_rvalid !== 1 || data_rvalid !== 0) begin
            fails++;
            $display("FAIL inst_response: rvalid inst=%b data=%b, expected 1/0", inst_rvalid, data_rvalid);
        end
        cyc();
        mem_rvalid = 0; mem_rdata = '0;
        cyc();
        tests++;
        if (iss_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL inst_read_drain: iss=%0d exp=%0d left, expected 0", iss_q.size(), exp_q.size());
        end
    endtask

    task automatic test_priority();
        apply_reset();
        mem_ready = 1;
        inst_valid = 1; inst_addr = 32'h100;
        data_valid = 1; data_addr = 32'h300;
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
        iss_q.push_back('{write: 1'b0, addr: 32'h100});
        iss_q.push_back('{write: 1'b0, addr: 32'h300});
        iss_q.push_back('{write: 1'b0, addr: 32'h104});
        @(negedge clk);
        tests++;
        if (inst_ready !== 1 || data_ready !== 0) begin
            fails++;
            $display("FAIL rr_grant1: ready inst=%b data=%b, expected 1/0", inst_ready, data_ready);
        end
        cyc();
        inst_addr = 32'h104;
        @(negedge clk);
        tests++;
        if (inst_ready !== 0 || data_ready !== 1) begin
            fails++;
            $display("FAIL rr_grant2: ready inst=%b data=%b, expected 0/1", inst_ready, data_ready);
        end
        cyc();
        data_addr = 32'h304;
        exp_q.push_back('{port: 1'b0, data: 32'h1111, err: 1'b0});
        mem_rvalid = 1; mem_rdata = 32'h1111;
        @(negedge clk);
        tests++;
        if (inst_ready !== 0 || data_ready !== 0 || mem_valid !== 0) begin
            fails++;
            $display("FAIL rr_full: ready inst=%b data=%b valid=%b, expected 0/0/0", inst_ready, data_ready, mem_valid);
        end
        cyc();
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        tests++;
        if (inst_ready !== 1 || data_ready !== 0) begin
            fails++;
            $display("FAIL rr_grant3: ready inst=%b data=%b, expected 1/0", inst_ready, data_ready);
        end
        cyc();
        inst_valid = 0; data_valid = 0;
        exp_q.push_back('{port: 1'b1, data: 32'h2222, err: 1'b0});
        respond(32'h2222, 1'b0);
        exp_q.push_back('{port: 1'b0, data: 32'h3333, err: 1'b0});
        respond(32'h3333, 1'b0);
`else
        iss_q.push_back('{write: 1'b0, addr: 32'h300});
        iss_q.push_back('{write: 1'b0, addr: 32'h100});
        @(negedge clk);
        tests++;
        if (inst_ready !== 0 || data_ready !== 1) begin
            fails++;
            $display("FAIL fixed_grant1: ready inst=%b data=%b, expected 0/1", inst_ready, data_ready);
        end
        cyc();
        data_valid = 0;
        @(negedge clk);
        tests++;
        if (inst_ready !== 1 || data_ready !== 0) begin
            fails++;
            $display("FAIL fixed_grant2: ready inst=%b data=%b, expected 1/0", inst_ready, data_ready);
        end
        cyc();
        inst_valid = 0;
        exp_q.push_back('{port: 1'b1, data: 32'hAAAA_0001, err: 1'b0});
        respond(32'hAAAA_0001, 1'b0);
        exp_q.push_back('{port: 1'b0, data: 32'hBBBB_0002, err: 1'b0});
        respond(32'hBBBB_0002, 1'b0);
`endif
        cyc();
        tests++;
        if (iss_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL priority_drain: iss=%0d exp=%0d left, expected 0", iss_q.size(), exp_q.size());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        mem_ready = 0;
        data_valid = 1; data_addr = 32'h200; data_write = 1;
        data_wdata = 32'hCAFE_1234; data_strobe = 4'b0011;
        iss_q.push_back('{write: 1'b1, addr: 32'h200});
        iss_q.push_back('{write: 1'b0, addr: 32'h180});
        cyc();
        inst_valid = 1; inst_addr = 32'h180;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (mem_valid !== 1 || mem_addr !== 32'h200 || mem_write !== 1 ||
                mem_strobe !== 4'b0011 || mem_wdata !== 32'hCAFE_1234 ||
                inst_ready !== 0 || data_ready !== 0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b addr=%h w=%b strb=%b wd=%h ready=%b/%b, expected 1 200 1 0011 cafe1234 0/0",
                         i, mem_valid, mem_addr, mem_write, mem_strobe, mem_wdata, inst_ready, data_ready);
            end
            cyc();
        end
        mem_ready = 1;
        @(negedge clk);
        tests++;
        if (data_ready !== 1 || inst_ready !== 0) begin
            fails++;
            $display("FAIL stall_release: ready inst=%b data=%b, expected 0/1", inst_ready, data_ready);
        end
        cyc();
        data_valid = 0; data_write = 0;
        @(negedge clk);
        tests++;
        if (inst_ready !== 1) begin
            fails++;
            $display("FAIL stall_inst_next: inst_ready=%b, expected 1", inst_ready);
        end
        cyc();
        inst_valid = 0;
        exp_q.push_back('{port: 1'b1, data: 32'h0, err: 1'b0});
        respond(32'h0, 1'b0);
        exp_q.push_back('{port: 1'b0, data: 32'h77, err: 1'b0});
        respond(32'h77, 1'b0);
        cyc();
        tests++;
        if (iss_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_drain: iss=%0d exp=%0d left, expected 0", iss_q.size(), exp_q.size());
        end
    endtask

    task automatic test_outstanding();
        apply_reset();
        mem_ready = 1;
        data_valid = 1; data_addr = 32'h400;
        iss_q.push_back('{write: 1'b0, addr: 32'h400});
        iss_q.push_back('{write: 1'b0, addr: 32'h404});
        iss_q.push_back('{write: 1'b0, addr: 32'h108});
        cyc();
        data_addr = 32'h404;
        cyc();
        data_valid = 0;
        inst_valid = 1; inst_addr = 32'h108;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (inst_ready !== 0 || mem_valid !== 0) begin
                fails++;
                $display("FAIL full_block[%0d]: inst_ready=%b mem_valid=%b, expected 0/0", i, inst_ready, mem_valid);
            end
            cyc();
        end
        exp_q.push_back('{port: 1'b1, data: 32'h4000, err: 1'b0});
        mem_rvalid = 1; mem_rdata = 32'h4000;
        @(negedge clk);
        tests++;
        if (inst_ready !== 0) begin
            fails++;
            $display("FAIL full_same_cycle: inst_ready=%b, expected 0", inst_ready);
        end
        cyc();
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        tests++;
        if (inst_ready !== 1) begin
            fails++;
            $display("FAIL full_next_cycle: inst_ready=%b, expected 1", inst_ready);
        end
        cyc();
        inst_valid = 0;
        exp_q.push_back('{port: 1'b1, data: 32'h4040, err: 1'b0});
        respond(32'h4040, 1'b0);
        exp_q.push_back('{port: 1'b0, data: 32'h1080, err: 1'b0});
        respond(32'h1080, 1'b0);
        cyc();
        tests++;
        if (iss_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL outstanding_drain: iss=%0d exp=%0d left, expected 0", iss_q.size(), exp_q.size());
        end
    endtask

    task automatic test_error();
        apply_reset();
        mem_ready = 1;
        data_valid = 1; data_addr = 32'h500;
        iss_q.push_back('{write: 1'b0, addr: 32'h500});
        cyc();
        data_valid = 0;
        exp_q.push_back('{port: 1'b1, data: 32'h0BAD, err: 1'b1});
        mem_rvalid = 1; mem_rdata = 32'h0BAD; mem_rerr = 1;
        @(negedge clk);
        tests++;
        if (data_rerr !== 1 || inst_rvalid !== 0 || inst_rerr !== 0 || inst_rdata !== '0) begin
            fails++;
            $display("FAIL data_error: data_err=%b inst v/e/d=%b/%b/%h, expected 1 and inst 0",
                     data_rerr, inst_rvalid, inst_rerr, inst_rdata);
        end
        cyc();
        mem_rvalid = 0; mem_rdata = '0; mem_rerr = 0;
        cyc();
        tests++;
        if (iss_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL error_drain: iss=%0d exp=%0d left, expected 0", iss_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_ready = 1;
        inst_valid = 1; inst_addr = 32'h100;
        iss_q.push_back('{write: 1'b0, addr: 32'h100});
        iss_q.push_back('{write: 1'b0, addr: 32'h104});
        cyc();
        inst_addr = 32'h104;
        cyc();
        inst_valid = 0;
        rst = 1;
        cyc();
        rst = 0;
        stray_ok = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'h9999;
        inst_valid = 1; inst_addr = 32'h10C;
        iss_q.push_back('{write: 1'b0, addr: 32'h10C});
        @(negedge clk);
        tests++;
        if (inst_rvalid !== 0 || data_rvalid !== 0 || inst_rdata !== '0 ||
            data_rdata !== '0 || inst_ready !== 1) begin
            fails++;
            $display("FAIL reset_mid_drop: rvalid=%b/%b rdata=%h/%h inst_ready=%b, expected 0/0 0/0 1",
                     inst_rvalid, data_rvalid, inst_rdata, data_rdata, inst_ready);
        end
        cyc();
        mem_rvalid = 0; mem_rdata = '0;
        inst_valid = 0;
        stray_ok = 1'b0;
        cyc();
        exp_q.push_back('{port: 1'b0, data: 32'h10C0, err: 1'b0});
        respond(32'h10C0, 1'b0);
        cyc();
        tests++;
        if (iss_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_drain: iss=%0d exp=%0d left, expected 0", iss_q.size(), exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_inst_read();
        test_priority();
        test_stall();
        test_outstanding();
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
